// File: rtl/pmc_program_sequencer_if.sv
// Host/PMC-side signal bundle for the PMC program sequencer.
interface pmc_program_sequencer_if;
  logic        cmd_load;
  logic        cmd_run;
  logic [5:0]  load_base;
  logic [6:0]  load_count;
  logic [5:0]  start_pc;
  logic        word_valid;
  logic [35:0] word_data;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        pmc_out0;
  logic        pmc_cs;
  logic        pmc_nrd;
  logic        pmc_bk;
  logic [12:0] pmc_ab;
  logic [7:0]  pmc_db;
  logic        pmc_start;

  // Environment side: board CPU glue plus the PMC OUT0 pin.
  modport master (
    output cmd_load, cmd_run, load_base, load_count, start_pc,
    output word_valid, word_data, pmc_out0,
    input  word_ready, busy, done, timeout_err,
    input  pmc_cs, pmc_nrd, pmc_bk, pmc_ab, pmc_db, pmc_start
  );

  // Sequencer side.
  modport slave (
    input  cmd_load, cmd_run, load_base, load_count, start_pc,
    input  word_valid, word_data, pmc_out0,
    output word_ready, busy, done, timeout_err,
    output pmc_cs, pmc_nrd, pmc_bk, pmc_ab, pmc_db, pmc_start
  );
endinterface

// File: rtl/pmc_program_sequencer.sv
// Host-side sequencer for the 052591 PMC: loads 36-bit microcode words into
// internal RAM through 5 byte writes each, then starts the PMC and waits for OUT0.
module pmc_program_sequencer #(
  parameter int unsigned WR_LOW  = 2,
  parameter int unsigned WR_HIGH = 2,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic                    pin_M12,
  input logic                    pin_RST,
  pmc_program_sequencer_if.slave bus
);

  localparam int unsigned WR_LEN     = WR_LOW + WR_HIGH + 1;
  localparam int unsigned PH_W       = $clog2(WR_LEN);
  localparam int unsigned BYTE_W     = 3;
  localparam int unsigned WORD_W     = 7;
  localparam int unsigned TMO_W      = 16;
  localparam int unsigned WORD_BITS  = 36;
  localparam int unsigned RUN_IGNORE = 4;

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(WR_LEN - 1);
  localparam logic [PH_W-1:0]   PH_LOW0  = PH_W'(1);
  localparam logic [PH_W-1:0]   PH_LOW1  = PH_W'(WR_LOW);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_IGN  = TMO_W'(RUN_IGNORE);
  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_LD, S_WAIT_WORD, S_BYTE, S_SET_PC, S_RUN, S_FIN
  } state_t;

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [BYTE_W-1:0]      byte_q, byte_d;
  logic [WORD_W-1:0]      words_q, words_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [WORD_BITS-1:0]   shreg_q, shreg_d;
  logic [5:0]             base_q, base_d;
  logic [5:0]             pc_q, pc_d;
  logic                   err_q, err_d;
  logic                   out0_s1_q, out0_s2_q;
  logic                   wr_last;

  logic                   cs_q, cs_d;
  logic                   ab9_q, ab9_d;
  logic [7:0]             db_q, db_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  // State register.
  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    words_d = words_q;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    base_d  = base_q;
    pc_d    = pc_q;
    err_d   = err_q;
    wr_last = (phase_q == PH_LAST);
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_load) begin
          state_d = S_SET_LD;
          phase_d = '0;
          base_d  = bus.load_base;
          words_d = (bus.load_count == 7'd0) ? 7'd64 : bus.load_count;
          err_d   = 1'b0;
        end else if (bus.cmd_run) begin
          state_d = S_SET_PC;
          phase_d = '0;
          pc_d    = bus.start_pc;
          err_d   = 1'b0;
        end
      end
      S_SET_LD: begin
        if (wr_last) begin
          state_d = S_WAIT_WORD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_WAIT_WORD: begin
        if (bus.word_valid && ready_q) begin
          state_d = S_BYTE;
          shreg_d = bus.word_data;
          byte_d  = '0;
          phase_d = '0;
        end
      end
      S_BYTE: begin
        if (wr_last) begin
          phase_d = '0;
          shreg_d = shreg_q >> 8;
          if (byte_q == BYTE_MAX) begin
            words_d = words_q - 7'd1;
            state_d = (words_q == 7'd1) ? S_FIN : S_WAIT_WORD;
          end else begin
            byte_d = byte_q + BYTE_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_SET_PC: begin
        if (wr_last) begin
          state_d = S_RUN;
          phase_d = '0;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_RUN: begin
        if (tmo_q != '1) tmo_d = tmo_q + 16'd1;
        if ((tmo_q >= TMO_IGN) && !out0_s2_q) begin
          state_d = S_FIN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next output values, derived from the next state so registered pins line up with it.
  always_comb begin
    cs_d    = 1'b1;
    ab9_d   = ab9_q;
    db_d    = db_q;
    start_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    ready_d = (state_d == S_WAIT_WORD);
    unique case (state_d)
      S_SET_LD: begin
        ab9_d = 1'b1;
        db_d  = {2'b10, base_d};
        cs_d  = !((phase_d >= PH_LOW0) && (phase_d <= PH_LOW1));
      end
      S_BYTE: begin
        ab9_d = 1'b0;
        db_d  = shreg_d[7:0];
        cs_d  = !((phase_d >= PH_LOW0) && (phase_d <= PH_LOW1));
      end
      S_SET_PC: begin
        ab9_d = 1'b1;
        db_d  = {2'b00, pc_d};
        cs_d  = !((phase_d >= PH_LOW0) && (phase_d <= PH_LOW1));
      end
      S_RUN:   start_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers and registered pins.
  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) begin
      phase_q <= '0;
      byte_q  <= '0;
      words_q <= '0;
      tmo_q   <= '0;
      shreg_q <= '0;
      base_q  <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      ab9_q   <= 1'b0;
      db_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      byte_q  <= byte_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      shreg_q <= shreg_d;
      base_q  <= base_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      ab9_q   <= ab9_d;
      db_q    <= db_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Two-flop synchroniser for OUT0; idles high like the PMC pin.
  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) begin
      out0_s1_q <= 1'b1;
      out0_s2_q <= 1'b1;
    end else begin
      out0_s1_q <= bus.pmc_out0;
      out0_s2_q <= out0_s1_q;
    end
  end

  assign bus.pmc_cs      = cs_q;
  assign bus.pmc_nrd     = 1'b1;
  assign bus.pmc_bk      = 1'b0;
  assign bus.pmc_ab      = {3'b000, ab9_q, 9'b0_0000_0000};
  assign bus.pmc_db      = db_q;
  assign bus.pmc_start   = start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;
  assign bus.word_ready  = ready_q;

endmodule

// File: tb/tb_pmc_program_sequencer.sv
// Scoreboard bench for pmc_program_sequencer: stimulus pushes expected PMC writes
// and done events; a negedge monitor pops and compares them as the pins move.
module tb_pmc_program_sequencer;
  localparam int unsigned WR_LOW  = 2;
  localparam int unsigned WR_HIGH = 2;
  localparam int unsigned TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmc_program_sequencer_if bus();

  pmc_program_sequencer #(.WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .TIMEOUT(TIMEOUT)) dut (
    .pin_M12(clk),
    .pin_RST(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int wr_seen = 0;
  int done_seen = 0;
  logic [8:0] exp_wr[$];
  logic       exp_done[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: bus-write framing, write contents and done events.
  logic        prev_cs = 1'b1;
  logic        prev_done = 1'b0;
  logic [12:0] prev_ab = '0;
  logic [7:0]  prev_db = '0;
  int          low_len = 0;
  always @(negedge clk) begin
    logic [8:0] e;
    logic       ed;
    if (rst) begin
      low_len = 0;
    end else begin
      if (prev_cs && !bus.pmc_cs) begin
        wr_seen++;
        low_len = 1;
        chk("setup_stable", 64'({prev_ab, prev_db}), 64'({bus.pmc_ab, bus.pmc_db}));
        chk("ab_unused_bits", 64'(bus.pmc_ab & 13'h1DFF), 64'(0));
        chk("nrd_bk", 64'({bus.pmc_nrd, bus.pmc_bk}), 64'(2'b10));
        if (exp_wr.size() == 0) begin
          fail("unexpected_write");
        end else begin
          e = exp_wr.pop_front();
          chk("write_ab9_db", 64'({bus.pmc_ab[9], bus.pmc_db}), 64'(e));
        end
      end else if (!prev_cs && !bus.pmc_cs) begin
        low_len++;
        chk("db_stable_low", 64'({bus.pmc_ab, bus.pmc_db}), 64'({prev_ab, prev_db}));
      end else if (!prev_cs && bus.pmc_cs) begin
        chk("cs_low_len", 64'(low_len), 64'(WR_LOW));
        chk("hold_stable", 64'({bus.pmc_ab, bus.pmc_db}), 64'({prev_ab, prev_db}));
      end
      if (bus.done) begin
        done_seen++;
        if (prev_done) fail("done_pulse_width");
        if (exp_done.size() == 0) begin
          fail("unexpected_done");
        end else begin
          ed = exp_done.pop_front();
          chk("timeout_err_at_done", 64'(bus.timeout_err), 64'(ed));
          chk("writes_left_at_done", 64'(exp_wr.size()), 64'(0));
        end
      end
    end
    prev_cs   = rst ? 1'b1 : bus.pmc_cs;
    prev_done = rst ? 1'b0 : bus.done;
    prev_ab   = bus.pmc_ab;
    prev_db   = bus.pmc_db;
  end

  // Reference model of one load command: SET_LD write then 5 little-endian bytes per word.
  task automatic push_load_model(input logic [5:0] base, input logic [35:0] words[$]);
    exp_wr.push_back({1'b1, 2'b10, base});
    foreach (words[i])
      for (int k = 0; k < 5; k++)
        exp_wr.push_back({1'b0, 8'(words[i] >> (8 * k))});
  endtask

  task automatic wait_idle(input int d0);
    int t = 0;
    while (bus.busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", 64'(bus.busy), 64'(0));
    chk("done_count", 64'(done_seen - d0), 64'(1));
  endtask

  task automatic feed_word(input logic [35:0] w, input int dly);
    int t = 0;
    @(negedge clk);
    while (!bus.word_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.word_ready) begin
      fail("word_ready_timeout");
      return;
    end
    for (int i = 0; i < dly; i++) begin
      chk("gap_cs_high", 64'(bus.pmc_cs), 64'(1));
      chk("gap_ready_held", 64'(bus.word_ready), 64'(1));
      @(negedge clk);
    end
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    @(negedge clk);
    chk("ready_drop_after_accept", 64'(bus.word_ready), 64'(0));
  endtask

  // extra: also pulse cmd_run together with cmd_load, and again while busy.
  task automatic do_load(input logic [5:0] base, input logic [6:0] cnt, input bit use_w0,
                         input logic [35:0] w0, input int slow_idx, input bit extra);
    int n = (cnt == 7'd0) ? 64 : int'(cnt);
    int d0 = done_seen;
    logic [35:0] words[$];
    for (int i = 0; i < n; i++)
      words.push_back((i == 0 && use_w0) ? w0 : {4'($urandom_range(0, 15)), 32'($urandom())});
    push_load_model(base, words);
    exp_done.push_back(1'b0);
    @(negedge clk);
    bus.cmd_load   = 1'b1;
    bus.load_base  = base;
    bus.load_count = cnt;
    if (extra) begin
      bus.cmd_run  = 1'b1;
      bus.start_pc = 6'h2A;
    end
    @(negedge clk);
    bus.cmd_load = 1'b0;
    bus.cmd_run  = 1'b0;
    chk("busy_after_load_cmd", 64'(bus.busy), 64'(1));
    if (extra) begin
      @(negedge clk);
      bus.cmd_run = 1'b1;
      @(negedge clk);
      bus.cmd_run = 1'b0;
    end
    for (int i = 0; i < n; i++)
      feed_word(words[i], (i == slow_idx) ? 10 : int'($urandom_range(0, 3)));
    wait_idle(d0);
  endtask

  // drop = cycles of pmc_start before OUT0 falls; 0 means OUT0 stuck high.
  task automatic do_run(input logic [5:0] pc, input int drop);
    int t = 0;
    int cnt = 0;
    int exp_cnt;
    int d0 = done_seen;
    exp_cnt = (drop == 0) ? int'(TIMEOUT) : ((drop + 2 > 5) ? drop + 2 : 5);
    exp_wr.push_back({1'b1, 2'b00, pc});
    exp_done.push_back(drop == 0);
    bus.pmc_out0 = 1'b1;
    @(negedge clk);
    bus.cmd_run  = 1'b1;
    bus.start_pc = pc;
    @(negedge clk);
    bus.cmd_run = 1'b0;
    while (!bus.pmc_start && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.pmc_start) begin
      fail("start_never_rose");
      return;
    end
    while (bus.pmc_start && cnt < int'(TIMEOUT) + 50) begin
      cnt++;
      if (drop != 0 && cnt == drop) bus.pmc_out0 = 1'b0;
      @(negedge clk);
    end
    chk("start_high_cycles", 64'(cnt), 64'(exp_cnt));
    chk("done_on_start_fall", 64'(bus.done), 64'(1));
    chk("busy_in_fin", 64'(bus.busy), 64'(1));
    bus.pmc_out0 = 1'b1;
    wait_idle(d0);
    chk("err_after_run", 64'(bus.timeout_err), 64'(drop == 0));
  endtask

  task automatic reset_mid_byte2();
    int t = 0;
    int w0 = wr_seen;
    logic [35:0] words[$];
    words.push_back(36'h9_8765_4321);
    push_load_model(6'd9, words);
    exp_done.push_back(1'b0);
    @(negedge clk);
    bus.cmd_load   = 1'b1;
    bus.load_base  = 6'd9;
    bus.load_count = 7'd1;
    @(negedge clk);
    bus.cmd_load = 1'b0;
    feed_word(words[0], 0);
    while (!(wr_seen == w0 + 4 && !bus.pmc_cs) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("reached_byte2_cs_low", 64'(bus.pmc_cs), 64'(0));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_cs", 64'(bus.pmc_cs), 64'(1));
    chk("rst_start", 64'(bus.pmc_start), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_ready", 64'(bus.word_ready), 64'(0));
    exp_wr.delete();
    exp_done.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b1;
    bus.cmd_load   = 1'b0;
    bus.cmd_run    = 1'b0;
    bus.load_base  = '0;
    bus.load_count = '0;
    bus.start_pc   = '0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.pmc_out0   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({bus.pmc_cs, bus.pmc_nrd, bus.pmc_bk, bus.pmc_start, bus.busy, bus.done,
             bus.timeout_err, bus.word_ready}), 64'(8'b1100_0000));
    chk("reset_ab_db", 64'({bus.pmc_ab, bus.pmc_db}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_load(6'd5, 7'd1, 1'b1, 36'hA_1234_5678, -1, 1'b0);
    w0 = wr_seen;
    do_load(6'h3C, 7'd3, 1'b0, '0, 1, 1'b0);
    chk("count3_writes", 64'(wr_seen - w0), 64'(16));
    w0 = wr_seen;
    do_load(6'h21, 7'd0, 1'b0, '0, -1, 1'b0);
    chk("count0_cs_pulses", 64'(wr_seen - w0), 64'(321));
    do_run(6'h12, 50);
    do_run(6'h07, 1);
    do_run(6'h33, 0);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", 64'(bus.timeout_err), 64'(1));
    do_load(6'd62, 7'd2, 1'b0, '0, -1, 1'b1);
    reset_mid_byte2();
    do_load(6'd11, 7'd2, 1'b0, '0, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_load(6'($urandom_range(0, 63)), 7'($urandom_range(1, 6)), 1'b0, '0, -1, 1'b0);
      else
        do_run(6'($urandom_range(0, 63)), int'($urandom_range(1, 60)));
    end
    repeat (4) @(negedge clk);
    chk("final_exp_wr_empty", 64'(exp_wr.size()), 64'(0));
    chk("final_exp_done_empty", 64'(exp_done.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
